// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle synchronous imem reads,
// {pc, inst} pushes into the instruction queue with a 1-entry skid buffer for back-pressure.
module inst_fetch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] PC_INC   = PC_W'(4),
    parameter logic [5:0]      HALT_OP  = 6'h3F
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     o_im_rd_en,
    output logic [PC_W-1:0]          o_im_addr,
    input  logic [INST_W-1:0]        i_im_rdata,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_w_en,
    output logic [PC_W+INST_W-1:0]   o_fifo_din,
    input  logic                     i_redirect_en,
    input  logic [PC_W-1:0]          i_redirect_pc,
    output logic                     o_fifo_flush,
    output logic                     o_halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_pending;
    logic [PC_W-1:0]   r_pend_pc;
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;

    logic              w_src_valid;
    logic [PC_W-1:0]   w_src_pc;
    logic [INST_W-1:0] w_src_inst;
    logic              w_src_halt;
    logic              w_issue;
    logic              w_write;
    logic              w_capture;

    always_comb begin
        w_src_valid = r_skid_valid | r_pending;
        w_src_pc    = r_skid_valid ? r_skid_pc   : r_pend_pc;
        w_src_inst  = r_skid_valid ? r_skid_inst : i_im_rdata;
        // Opcode field inst[0:5] uses MSB-first bit numbering, i.e. the top six bits.
        w_src_halt  = w_src_valid && (w_src_inst[INST_W-1 -: 6] == HALT_OP);
        w_issue     = !i_reset && (r_state == ST_RUN) && !i_redirect_en && !r_skid_valid &&
                      !(r_pending && i_fifo_full) && !w_src_halt;
        w_write     = w_src_valid && !i_fifo_full && !i_redirect_en;
        // A response that cannot be written this cycle parks in the skid buffer.
        w_capture   = r_pending && (i_fifo_full || r_skid_valid);
    end

    assign o_im_rd_en   = w_issue;
    assign o_im_addr    = r_pc;
    assign o_fifo_w_en  = w_write;
    assign o_fifo_din   = {w_src_pc, w_src_inst};
    assign o_fifo_flush = i_redirect_en;
    assign o_halted     = (r_state == ST_HALTED);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pending    <= 1'b0;
            r_pend_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
        end else if (i_redirect_en) begin
            r_state      <= ST_RUN;
            r_pc         <= i_redirect_pc;
            r_pending    <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pend_pc <= r_pc;
                r_pc      <= r_pc + PC_INC;
            end
            if (w_capture) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_pend_pc;
                r_skid_inst  <= i_im_rdata;
            end else if (w_write) begin
                r_skid_valid <= 1'b0;
            end
            if (w_write && w_src_halt) begin
                r_state <= ST_HALTED;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized back-pressure and redirects,
// checked every cycle against an expected in-order PC stream model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        im_rd_en;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [63:0] fifo_din;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fifo_flush;
    logic        halted;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] g_halt_pc;
    logic [31:0] wr_log[$];
    int          wr_cyc[$];

    logic [31:0] exp_pc;
    bit          halted_exp;
    int          idle;

    inst_fetch_unit #(
        .PC_W    (32),
        .INST_W  (32),
        .RESET_PC(32'h0),
        .PC_INC  (32'h4),
        .HALT_OP (6'h3F)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .o_im_rd_en   (im_rd_en),
        .o_im_addr    (im_addr),
        .i_im_rdata   (im_rdata),
        .i_fifo_full  (fifo_full),
        .o_fifo_w_en  (fifo_w_en),
        .o_fifo_din   (fifo_din),
        .i_redirect_en(redirect_en),
        .i_redirect_pc(redirect_pc),
        .o_fifo_flush (fifo_flush),
        .o_halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: opcode derived from the address, never HALT except at g_halt_pc.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        logic [5:0] op;
        if (pc == g_halt_pc) return {6'h3F, pc[25:0]};
        op = (pc[7:2] == 6'h3F) ? 6'h01 : pc[7:2];
        return {op, pc[25:0] ^ 26'h0155AA5};
    endfunction

    always @(posedge clk) if (im_rd_en) im_rdata <= inst_of(im_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle model: writes must follow the PC stream exactly, stop after HALT, restart on redirect.
    initial begin
        logic [31:0] e_inst;
        exp_pc     = 32'h0;
        halted_exp = 1'b0;
        idle       = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_pc     = 32'h0;
                halted_exp = 1'b0;
                idle       = 0;
            end else begin
                check("flush", {63'b0, fifo_flush}, {63'b0, redirect_en});
                check("halted", {63'b0, halted}, {63'b0, halted_exp});
                if (halted_exp) check("rd_en_halted", {63'b0, im_rd_en}, 64'd0);
                if (fifo_full || redirect_en || halted_exp)
                    check("wen_blocked", {63'b0, fifo_w_en}, 64'd0);
                if (fifo_w_en) begin
                    wr_log.push_back(fifo_din[63:32]);
                    wr_cyc.push_back(cyc);
                end
                if (redirect_en) begin
                    exp_pc     = redirect_pc;
                    halted_exp = 1'b0;
                    idle       = 0;
                end else if (fifo_full || halted_exp) begin
                    idle = 0;
                end else if (fifo_w_en) begin
                    e_inst = inst_of(exp_pc);
                    check("din", fifo_din, {exp_pc, e_inst});
                    if (e_inst[31:26] == 6'h3F) halted_exp = 1'b1;
                    exp_pc = exp_pc + 32'd4;
                    idle   = 0;
                end else begin
                    idle++;
                    check("stall_len", 64'(idle > 1), 64'd0);
                end
            end
        end
    end

    initial begin
        int dcyc;
        int r;
        logic [31:0] tgt;
        reset       = 1'b1;
        fifo_full   = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        g_halt_pc   = 32'h8000_0000;
        #1;
        check("rst_rd_en", {63'b0, im_rd_en}, 64'd0);
        check("rst_wen", {63'b0, fifo_w_en}, 64'd0);
        check("rst_halted", {63'b0, halted}, 64'd0);

        // 1: stream from reset; first write lands two edges after deassertion
        step(2);
        wr_log.delete();
        wr_cyc.delete();
        reset = 1'b0;
        dcyc  = cyc;
        step(6);
        check("t1_count", 64'(wr_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) check("t1_pc", {32'b0, wr_log[i]}, 64'(i * 4));
        check("t1_first_cyc", 64'(wr_cyc[0]), 64'(dcyc + 1));
        check("t1_last_cyc", 64'(wr_cyc[3]), 64'(dcyc + 4));

        // 2: three cycles of back-pressure mid-stream
        wr_log.delete();
        fifo_full = 1'b1;
        step(3);
        fifo_full = 1'b0;
        step(8);
        check("t2_count", 64'(wr_log.size() >= 6), 64'd1);
        for (int i = 0; i < 6; i++) check("t2_pc", {32'b0, wr_log[i]}, 64'(20 + i * 4));

        // 3: redirect while the skid holds an entry
        fifo_full = 1'b1;
        step(2);
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("t3_flush", {63'b0, fifo_flush}, 64'd1);
        check("t3_wen", {63'b0, fifo_w_en}, 64'd0);
        step(1);
        redirect_en = 1'b0;
        fifo_full   = 1'b0;
        wr_log.delete();
        step(4);
        check("t3_pc0", {32'b0, wr_log[0]}, 64'h100);
        check("t3_pc1", {32'b0, wr_log[1]}, 64'h104);

        // 4: HALT at 0x10, then resume by redirect to 0x40
        redirect_en = 1'b1;
        redirect_pc = 32'h0;
        g_halt_pc   = 32'h10;
        step(1);
        redirect_en = 1'b0;
        wr_log.delete();
        step(10);
        check("t4_count", 64'(wr_log.size()), 64'd5);
        check("t4_last", {32'b0, wr_log[4]}, 64'h10);
        check("t4_halted", {63'b0, halted}, 64'd1);
        check("t4_rd_en", {63'b0, im_rd_en}, 64'd0);
        redirect_en = 1'b1;
        redirect_pc = 32'h40;
        g_halt_pc   = 32'h8000_0000;
        step(1);
        redirect_en = 1'b0;
        check("t4_unhalt", {63'b0, halted}, 64'd0);
        wr_log.delete();
        step(4);
        check("t4_pc0", {32'b0, wr_log[0]}, 64'h40);
        check("t4_pc1", {32'b0, wr_log[1]}, 64'h44);

        // 5: redirect on the very cycle the HALT at 0x8 would be written
        redirect_en = 1'b1;
        redirect_pc = 32'h0;
        g_halt_pc   = 32'h8;
        step(1);
        redirect_en = 1'b0;
        wr_log.delete();
        step(3);
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        g_halt_pc   = 32'h8000_0000;
        #1;
        check("t5_wen", {63'b0, fifo_w_en}, 64'd0);
        step(1);
        redirect_en = 1'b0;
        check("t5_halted", {63'b0, halted}, 64'd0);
        step(4);
        check("t5_count", 64'(wr_log.size() >= 4), 64'd1);
        check("t5_pc0", {32'b0, wr_log[0]}, 64'h0);
        check("t5_pc1", {32'b0, wr_log[1]}, 64'h4);
        check("t5_pc2", {32'b0, wr_log[2]}, 64'h200);
        check("t5_pc3", {32'b0, wr_log[3]}, 64'h204);

        // 6: asynchronous reset mid-stream, with and without back-pressure
        for (int k = 0; k < 2; k++) begin
            step(3);
            fifo_full = (k == 0);
            #1;
            reset = 1'b1;
            #1;
            check("t6_rd_en", {63'b0, im_rd_en}, 64'd0);
            check("t6_wen", {63'b0, fifo_w_en}, 64'd0);
            check("t6_halted", {63'b0, halted}, 64'd0);
            step(1);
            reset     = 1'b0;
            fifo_full = 1'b0;
            wr_log.delete();
            step(4);
            check("t6_pc0", {32'b0, wr_log[0]}, 64'h0);
            check("t6_pc1", {32'b0, wr_log[1]}, 64'h4);
        end

        // Randomized back-pressure, redirects (some near the wrap point) and HALTs
        for (int i = 0; i < 4000; i++) begin
            step(1);
            fifo_full = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 99));
            redirect_en = (r < 3) || (halted_exp && r < 20);
            if (redirect_en) begin
                case ($urandom_range(0, 2))
                    0:       tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    1:       tgt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4);
                    default: tgt = 32'h1000;
                endcase
                redirect_pc = tgt;
                g_halt_pc   = $urandom_range(0, 1) ? tgt + 32'($urandom_range(1, 10) * 4)
                                                   : tgt - 32'd4;
            end else begin
                redirect_pc = $urandom;
            end
        end
        step(1);
        fifo_full   = 1'b0;
        redirect_en = 1'b0;
        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
